// File: rtl/fp16_pkg.sv
// ============================================================================
// Module : fp16_pkg
// Brief  : Shared fp16 (1/5/10) types, constants and FSM encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fp16_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } fp16_t;

  localparam int          FP16_BIAS    = 15;
  localparam logic [4:0]  FP16_EXP_MAX = 5'd31;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } acc_state_t;

  // Leading-zero count of a 14-bit field; 14 when the field is zero.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    lzc14 = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) lzc14 = 4'(13 - i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_align.sv
// ============================================================================
// Module : fp_align
// Brief  : Orders acc/product by magnitude and right-aligns the smaller one.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_align (
  input  logic [15:0] acc,
  input  logic [15:0] prod,
  output logic [13:0] sig_a,
  output logic [13:0] sig_b,
  output logic [4:0]  exp_a,
  output logic        sign_a,
  output logic        eff_sub,
  output logic        sticky
);
  import fp16_pkg::*;

  fp16_t       w_a;
  fp16_t       w_b;
  logic [10:0] w_sig_big;
  logic [10:0] w_sig_small;
  logic [4:0]  w_diff;
  logic [27:0] w_shift;

  always_comb begin
    if (acc[14:0] >= prod[14:0]) begin
      w_a = fp16_t'(acc);
      w_b = fp16_t'(prod);
    end else begin
      w_a = fp16_t'(prod);
      w_b = fp16_t'(acc);
    end
    // A zero exponent field means zero; its mantissa is ignored.
    w_sig_big   = (w_a.exp != 5'd0) ? {1'b1, w_a.man} : 11'd0;
    w_sig_small = (w_b.exp != 5'd0) ? {1'b1, w_b.man} : 11'd0;
    w_diff      = w_a.exp - w_b.exp;
    w_shift     = {w_sig_small, 17'd0} >> w_diff;

    sig_a   = {w_sig_big, 3'b000};
    exp_a   = w_a.exp;
    sign_a  = w_a.sign;
    eff_sub = w_a.sign ^ w_b.sign;
    if (w_diff > 5'd13) begin
      sig_b  = 14'd0;
      sticky = |w_sig_small;
    end else begin
      sig_b  = w_shift[27:14] | {13'd0, |w_shift[13:0]};
      sticky = |w_shift[13:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_accum.sv
// ============================================================================
// Module : fp_accum
// Brief  : 3-cycle sequential fp16 group accumulator, truncating, flush-to-zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_product,
  input  logic             in_overflow,
  input  logic             in_inexact,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_inexact
);
  import fp16_pkg::*;

  acc_state_t       r_state;
  fp16_t            r_acc;
  fp16_t            r_prod;
  logic [CNT_W-1:0] r_count;
  logic             r_last, r_pin_ovf, r_pin_inx;
  logic             r_ovf, r_unf, r_inx;
  logic             r_in_ready, r_out_valid;
  logic [13:0]      r_sig_a, r_sig_b;
  logic [4:0]       r_exp;
  logic             r_sign, r_sub, r_sticky;

  logic [13:0]      w_sig_a, w_sig_b;
  logic [4:0]       w_exp_a;
  logic             w_sign_a, w_sub, w_sticky;

  fp_align u_align (
    .acc     (r_acc),
    .prod    (r_prod),
    .sig_a   (w_sig_a),
    .sig_b   (w_sig_b),
    .exp_a   (w_exp_a),
    .sign_a  (w_sign_a),
    .eff_sub (w_sub),
    .sticky  (w_sticky)
  );

  logic [14:0]       w_sum;
  logic [3:0]        w_lz;
  logic [4:0]        w_sh;
  logic [13:0]       w_norm;
  logic [9:0]        w_man;
  logic              w_drop;
  logic signed [6:0] w_exp;
  logic [15:0]       w_res;
  logic              w_res_ovf, w_res_unf, w_res_inx;

  always_comb begin
    w_sum     = r_sub ? ({1'b0, r_sig_a} - {1'b0, r_sig_b})
                      : ({1'b0, r_sig_a} + {1'b0, r_sig_b});
    w_lz      = lzc14(w_sum[13:0]);
    // Shifting one past the leading one drops the hidden bit.
    w_sh      = {1'b0, w_lz} + 5'd1;
    w_norm    = w_sum[13:0] << w_sh;
    w_res     = FP16_ZERO;
    w_res_ovf = 1'b0;
    w_res_unf = 1'b0;
    w_res_inx = 1'b0;
    if (w_sum[14]) begin
      w_man  = w_sum[13:4];
      w_drop = |w_sum[3:0];
      w_exp  = $signed({2'b00, r_exp}) + 7'sd1;
    end else begin
      w_man  = w_norm[13:4];
      w_drop = |w_norm[3:0];
      w_exp  = $signed({2'b00, r_exp}) - $signed({3'b000, w_lz});
    end

    if (r_acc.exp == FP16_EXP_MAX) begin
      w_res     = FP16_POS_INF | {r_acc.sign, 15'd0};
      w_res_ovf = 1'b1;
    end else if (r_prod.exp == FP16_EXP_MAX) begin
      w_res     = FP16_POS_INF | {r_prod.sign, 15'd0};
      w_res_ovf = 1'b1;
    end else if (w_sum == 15'd0) begin
      w_res_inx = r_sticky;
    end else if (w_exp >= 7'sd31) begin
      w_res     = FP16_POS_INF | {r_sign, 15'd0};
      w_res_ovf = 1'b1;
      w_res_inx = w_drop | r_sticky;
    end else if (w_exp < 7'sd1) begin
      w_res_unf = 1'b1;
      w_res_inx = w_drop | r_sticky;
    end else begin
      w_res     = {r_sign, w_exp[4:0], w_man};
      w_res_inx = w_drop | r_sticky;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_acc       <= fp16_t'(FP16_ZERO);
      r_prod      <= fp16_t'(FP16_ZERO);
      r_count     <= '0;
      r_last      <= 1'b0;
      r_pin_ovf   <= 1'b0;
      r_pin_inx   <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inx       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sig_a     <= '0;
      r_sig_b     <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_prod     <= fp16_t'(in_product);
            r_last     <= in_last;
            r_pin_ovf  <= in_overflow;
            r_pin_inx  <= in_inexact;
            r_in_ready <= 1'b0;
            r_state    <= ALIGN;
          end
        end
        ALIGN: begin
          r_sig_a  <= w_sig_a;
          r_sig_b  <= w_sig_b;
          r_exp    <= w_exp_a;
          r_sign   <= w_sign_a;
          r_sub    <= w_sub;
          r_sticky <= w_sticky;
          r_state  <= ADD;
        end
        ADD: begin
          r_acc <= fp16_t'(w_res);
          if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
          r_ovf <= r_ovf | w_res_ovf | r_pin_ovf;
          r_unf <= r_unf | w_res_unf;
          r_inx <= r_inx | w_res_inx | r_pin_inx;
          if (r_last) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_acc       <= fp16_t'(FP16_ZERO);
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_inx       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_sum       = r_acc;
  assign out_count     = r_count;
  assign out_overflow  = r_ovf;
  assign out_underflow = r_unf;
  assign out_inexact   = r_inx;

endmodule

`default_nettype wire
